multicycle_controller: RTL
==========================

# multicycle_controller

Multicycle sequencer for the 16-bit RISC CPU. It replaces the single-cycle decode path with a Moore-style state machine. Each instruction is split into fetch, decode, execute, memory and writeback steps, so the shared memory port and the ALU are reused across cycles. It also handshakes with a memory that may stall. It sits between the instruction register's opcode field and the multicycle datapath's mux selects and enables.

## Interface
- `n`, 16, datapath width; sets the width of `instret`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  4  opcode from the instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pcwrite`  out  1  PC load enable.
- `irwrite`  out  1  instruction register load.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memread`, `memwrite`  out  1 each  memory strobes.
- `memtoreg`  out  1  register writeback source: 1 = memory data register.
- `regdst`  out  1  destination select: 1 = rd field.
- `regwrite`  out  1  register file write.
- `save`  out  1  write the return address to the link register (JAL).
- `alusrca`  out  1  ALU A input: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B input: 00 = register B, 01 = instruction increment, 10 = sign-extended immediate.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- `halted`  out  1  high in the HALT state.
- `instret`  out  n  count of retired instructions.

## Operation
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
  - 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 J, A JAL, F HALT.
  - B–E are illegal; they are treated as NOP and go DECODE→FETCH.
- States and actions:
  - FETCH: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `pcsrc`=00, `alucontrol`=add. `irwrite` and `pcwrite` are asserted only in the cycle `mem_ready`=1; they are Mealy on `mem_ready`. The FSM holds in FETCH while `mem_ready`=0, then goes to DECODE.
  - DECODE: `alusrca`=0, `alusrcb`=10, add; this precomputes the branch target into ALUOut. Next state by op: 0–4→EXEC, 5→ADDIEX, 6/7→MEMADR, 8→BRANCH, 9→JUMP, A→JAL, F→HALT, B–E→FETCH.
  - EXEC: `alusrca`=1, `alusrcb`=00, `alucontrol` from op → ALUWB.
  - ALUWB: `regwrite`=1, `regdst`=1, `memtoreg`=0 → FETCH.
  - ADDIEX: `alusrca`=1, `alusrcb`=10, add → ADDIWB.
  - ADDIWB: `regwrite`=1, `regdst`=0, `memtoreg`=0 → FETCH.
  - MEMADR: `alusrca`=1, `alusrcb`=10, add → MEMRD if op=6, MEMWR if op=7.
  - MEMRD: `memread`=1, `iord`=1; holds until `mem_ready` → MEMWB.
  - MEMWB: `regwrite`=1, `regdst`=0, `memtoreg`=1 → FETCH.
  - MEMWR: `memwrite`=1, `iord`=1; holds until `mem_ready` → FETCH.
  - BRANCH: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01, `pcwrite`=`zero` → FETCH.
  - JUMP: `pcsrc`=10, `pcwrite`=1 → FETCH.
  - JAL: `pcsrc`=10, `pcwrite`=1, `save`=1, `regwrite`=1 → FETCH.
  - HALT: `halted`=1, all other outputs 0; absorbing until reset.
- Every output not listed for a state is 0.
- `instret` increments by 1 on each transition into FETCH from any state other than FETCH. It wraps from 2^n−1 to 0. It does not increment on entry to HALT.
- The memory strobes are never both high. `memread`/`memwrite` stay asserted for the entire wait in MEMRD, MEMWR and FETCH.

## Timing
- While `reset`=0: state=FETCH, `instret`=0, and every output is forced to 0, including `memread`, `irwrite` and `pcwrite`. Reset asynchronously aborts any state, including a memory wait; no partial write is retried.
- On the first rising edge after `reset` rises, FETCH is active with `memread`=1.
- Cycles per instruction with zero wait (`mem_ready` tied high):
  - R-type 4, ADDI 4, LW 5, SW 4.
  - BEQ 3, J 3, JAL 3.
  - Illegal opcode 2.
- Each memory wait cycle adds exactly 1 cycle to FETCH, MEMRD or MEMWR.
- `op` is sampled only in DECODE and MEMADR; changes of `op` in other states are ignored.

## Test plan
- Reset then an ADD stream with `mem_ready`=1: all outputs are 0 during reset. Each ADD takes 4 cycles with `alucontrol`=010 in EXEC and `regwrite`=1, `regdst`=1 in ALUWB. `instret`=3 after 12 cycles.
- LW with `mem_ready` low for 3 cycles in MEMRD: `memread`=1, `iord`=1 are held 4 cycles, then MEMWB asserts `memtoreg`=1, `regwrite`=1. The instruction totals 8 cycles.
- BEQ with `zero`=1 and then with `zero`=0: in BRANCH, `pcsrc`=01 and `alucontrol`=110 in both cases. `pcwrite` is 1 and 0 respectively.
- JAL, SW, opcode C, then HALT: checks `save`=1 with `pcwrite`=1, `memwrite`=1 for one cycle, and the 2-cycle NOP. `halted` stays 1 indefinitely and `instret` stays frozen at 3.
- Assert `reset` in the middle of a MEMWR stall: `memwrite` drops immediately with no clock edge, and the FSM restarts in FETCH with `instret`=0.
- Preload `instret` to 0xFFFF by running 65535 NOPs: the next retire wraps it to 0x0000.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the datapath/memory.
interface multicycle_controller_if #(
  parameter int unsigned n = 16
);
  logic [3:0]   op;
  logic         zero;
  logic         mem_ready;
  logic         pcwrite;
  logic         irwrite;
  logic         iord;
  logic         memread;
  logic         memwrite;
  logic         memtoreg;
  logic         regdst;
  logic         regwrite;
  logic         save;
  logic         alusrca;
  logic [1:0]   alusrcb;
  logic [1:0]   pcsrc;
  logic [2:0]   alucontrol;
  logic         halted;
  logic [n-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output pcwrite, irwrite, iord, memread, memwrite, memtoreg, regdst,
           regwrite, save, alusrca, alusrcb, pcsrc, alucontrol, halted, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcwrite, irwrite, iord, memread, memwrite, memtoreg, regdst,
           regwrite, save, alusrca, alusrcb, pcsrc, alucontrol, halted, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the 16-bit RISC CPU: fetch/decode/execute/memory/
// writeback steps with a stallable memory handshake and a retire counter.
module multicycle_controller #(
  parameter int unsigned n = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JAL, S_HALT
  } state_t;

  state_t       state_q, state_d;
  logic         started_q, started_d;
  logic [n-1:0] instret_q, instret_d;

  logic       memread_q, memread_d;
  logic       memwrite_q, memwrite_d;
  logic       iord_q, iord_d;
  logic       memtoreg_q, memtoreg_d;
  logic       regdst_q, regdst_d;
  logic       regwrite_q, regwrite_d;
  logic       save_q, save_d;
  logic       alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic [1:0] pcsrc_q, pcsrc_d;
  logic [2:0] alucontrol_q, alucontrol_d;
  logic       halted_q, halted_d;
  logic       fetch_q, fetch_d;
  logic       branch_q, branch_d;
  logic       jump_q, jump_d;

  // Next state, retire count, and the Moore outputs of the state being entered.
  // Outputs are registered from state_d; started_q keeps everything quiet
  // until the first edge after reset so FETCH only reads once truly active.
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    instret_d = instret_q;

    if (started_q) begin
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (bus.op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: state_d = S_EXEC;
            4'h5:                         state_d = S_ADDIEX;
            4'h6, 4'h7:                   state_d = S_MEMADR;
            4'h8:                         state_d = S_BRANCH;
            4'h9:                         state_d = S_JUMP;
            4'hA:                         state_d = S_JAL;
            4'hF:                         state_d = S_HALT;
            default:                      state_d = S_FETCH;
          endcase
        end
        S_EXEC:   state_d = S_ALUWB;
        S_ALUWB:  state_d = S_FETCH;
        S_ADDIEX: state_d = S_ADDIWB;
        S_ADDIWB: state_d = S_FETCH;
        S_MEMADR: state_d = (bus.op == 4'h6) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
        S_MEMWB:  state_d = S_FETCH;
        S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
        S_BRANCH: state_d = S_FETCH;
        S_JUMP:   state_d = S_FETCH;
        S_JAL:    state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
    end

    if (started_q && (state_d == S_FETCH) && (state_q != S_FETCH))
      instret_d = instret_q + n'(1);

    memread_d    = 1'b0;
    memwrite_d   = 1'b0;
    iord_d       = 1'b0;
    memtoreg_d   = 1'b0;
    regdst_d     = 1'b0;
    regwrite_d   = 1'b0;
    save_d       = 1'b0;
    alusrca_d    = 1'b0;
    alusrcb_d    = 2'b00;
    pcsrc_d      = 2'b00;
    alucontrol_d = 3'b000;
    halted_d     = 1'b0;
    fetch_d      = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;

    case (state_d)
      S_FETCH: begin
        memread_d    = 1'b1;
        alusrcb_d    = 2'b01;
        alucontrol_d = 3'b010;
        fetch_d      = 1'b1;
      end
      S_DECODE: begin
        alusrcb_d    = 2'b10;
        alucontrol_d = 3'b010;
      end
      S_EXEC: begin
        alusrca_d = 1'b1;
        case (bus.op)
          4'h1:    alucontrol_d = 3'b110;
          4'h2:    alucontrol_d = 3'b000;
          4'h3:    alucontrol_d = 3'b001;
          4'h4:    alucontrol_d = 3'b111;
          default: alucontrol_d = 3'b010;
        endcase
      end
      S_ALUWB: begin
        regwrite_d = 1'b1;
        regdst_d   = 1'b1;
      end
      S_ADDIEX, S_MEMADR: begin
        alusrca_d    = 1'b1;
        alusrcb_d    = 2'b10;
        alucontrol_d = 3'b010;
      end
      S_ADDIWB: regwrite_d = 1'b1;
      S_MEMRD: begin
        memread_d = 1'b1;
        iord_d    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_d = 1'b1;
        memtoreg_d = 1'b1;
      end
      S_MEMWR: begin
        memwrite_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_BRANCH: begin
        alusrca_d    = 1'b1;
        alucontrol_d = 3'b110;
        pcsrc_d      = 2'b01;
        branch_d     = 1'b1;
      end
      S_JUMP: begin
        pcsrc_d = 2'b10;
        jump_d  = 1'b1;
      end
      S_JAL: begin
        pcsrc_d    = 2'b10;
        jump_d     = 1'b1;
        save_d     = 1'b1;
        regwrite_d = 1'b1;
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  // State, retire counter and registered outputs; reset clears every output at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      started_q    <= 1'b0;
      instret_q    <= '0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      iord_q       <= 1'b0;
      memtoreg_q   <= 1'b0;
      regdst_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      save_q       <= 1'b0;
      alusrca_q    <= 1'b0;
      alusrcb_q    <= '0;
      pcsrc_q      <= '0;
      alucontrol_q <= '0;
      halted_q     <= 1'b0;
      fetch_q      <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      instret_q    <= instret_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      iord_q       <= iord_d;
      memtoreg_q   <= memtoreg_d;
      regdst_q     <= regdst_d;
      regwrite_q   <= regwrite_d;
      save_q       <= save_d;
      alusrca_q    <= alusrca_d;
      alusrcb_q    <= alusrcb_d;
      pcsrc_q      <= pcsrc_d;
      alucontrol_q <= alucontrol_d;
      halted_q     <= halted_d;
      fetch_q      <= fetch_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
    end
  end

  // Fetch load enables follow mem_ready and the branch follows zero within the cycle.
  assign bus.irwrite    = fetch_q & bus.mem_ready;
  assign bus.pcwrite    = (fetch_q & bus.mem_ready) | (branch_q & bus.zero) | jump_q;
  assign bus.memread    = memread_q;
  assign bus.memwrite   = memwrite_q;
  assign bus.iord       = iord_q;
  assign bus.memtoreg   = memtoreg_q;
  assign bus.regdst     = regdst_q;
  assign bus.regwrite   = regwrite_q;
  assign bus.save       = save_q;
  assign bus.alusrca    = alusrca_q;
  assign bus.alusrcb    = alusrcb_q;
  assign bus.pcsrc      = pcsrc_q;
  assign bus.alucontrol = alucontrol_q;
  assign bus.halted     = halted_q;
  assign bus.instret    = instret_q;

endmodule
